// File: rtl/shift_pkg.sv
// Shared types and constants for the shift command path.
package shift_pkg;

    localparam int SHIFT_W     = 8;
    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    typedef struct packed {
        logic               dir;
        logic [2:0]         shamt;
        logic [SHIFT_W-1:0] in;
    } shift_cmd_t;

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit logical barrel shifter; dir = 1 shifts left, dir = 0 shifts right, zero fill.
module barrel_shifter (
    input  logic [7:0] in,
    input  logic [2:0] shamt,
    input  logic       dir,
    output logic [7:0] out
);

    always_comb begin
        if (dir) begin
            out = in << shamt;
        end else begin
            out = in >> shamt;
        end
    end

endmodule

// File: rtl/shift_cmd_queue.sv
// Command FIFO in front of barrel_shifter with a registered, handshaked result stage.
module shift_cmd_queue
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SHIFT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [W-1:0]               cmd_in,
    input  logic [2:0]                 cmd_shamt,
    input  logic                       cmd_dir,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [W-1:0]               res_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    shift_cmd_t         mem_q [DEPTH];
    shift_cmd_t         mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               res_valid_q, res_valid_d;
    logic [W-1:0]       res_out_q, res_out_d;

    shift_cmd_t         head;
    logic [W-1:0]       sh_out;
    logic               push;
    logic               pop;

    // Ready comes only from the registered count, so a full queue stays
    // closed even on a cycle where the head is being popped.
    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (count_q != '0) & (~res_valid_q | res_ready);
    assign head      = mem_q[rd_ptr_q];

    barrel_shifter u_shifter (
        .in    (head.in),
        .shamt (head.shamt),
        .dir   (head.dir),
        .out   (sh_out)
    );

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        res_valid_d = res_valid_q;
        res_out_d   = res_out_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{dir: cmd_dir, shamt: cmd_shamt, in: cmd_in};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            res_out_d   = sh_out;
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
        end
    end

    // Storage needs no reset: entries are only read once count marks them valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign res_valid = res_valid_q;
    assign res_out   = res_out_q;
    assign count     = count_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue: expected results queued on accept, compared on consume.
module tb_shift_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_in;
    logic [2:0] cmd_shamt;
    logic       cmd_dir;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_out;
    logic [2:0] count;

    int         n_chk = 0;
    int         n_err = 0;
    int         n_consumed = 0;
    logic [7:0] sb[$];

    shift_cmd_queue #(.DEPTH(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_in    (cmd_in),
        .cmd_shamt (cmd_shamt),
        .cmd_dir   (cmd_dir),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bit-level reference: output bit i takes input bit i-s (left) or i+s (right).
    function automatic logic [7:0] model(input logic [7:0] din, input logic [2:0] sh, input logic dir);
        logic [7:0] r;
        int         src;
        for (int i = 0; i < 8; i++) begin
            src  = dir ? (i - int'(sh)) : (i + int'(sh));
            r[i] = (src >= 0 && src < 8) ? din[src] : 1'b0;
        end
        return r;
    endfunction

    // Handshakes are observed mid-cycle; they take effect on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                n_consumed++;
                if (sb.size() == 0) begin
                    chk("spurious_res", 32'd1, 32'd0);
                end else begin
                    chk("res_out", {24'd0, res_out}, {24'd0, sb.pop_front()});
                end
            end
            if (cmd_valid && cmd_ready) begin
                sb.push_back(model(cmd_in, cmd_shamt, cmd_dir));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] din, input logic [2:0] sh, input logic dir);
        int tries;
        cmd_in    = din;
        cmd_shamt = sh;
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        tries     = 0;
        while (!cmd_ready && tries < 50) begin
            step();
            tries++;
        end
        if (tries >= 50) chk("push_timeout", 32'd1, 32'd0);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int tries;
        res_ready = 1'b1;
        tries     = 0;
        while ((sb.size() != 0 || res_valid || count != 0) && tries < 60) begin
            step();
            tries++;
        end
        if (tries >= 60) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_in    = '0;
        cmd_shamt = '0;
        cmd_dir   = 1'b0;
        res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_out", {24'd0, res_out}, 32'h00);
        chk("rst_count", {29'd0, count}, 32'd0);

        // Left shift with latency check: no empty-bypass
        res_ready = 1'b1;
        push(8'b0111_0100, 3'd3, 1'b1);
        chk("lat_not_yet", {31'd0, res_valid}, 32'd0);
        chk("lat_count1", {29'd0, count}, 32'd1);
        step();
        chk("lat_valid", {31'd0, res_valid}, 32'd1);
        chk("left_const", {24'd0, res_out}, 32'hA0);
        step();
        chk("left_released", {31'd0, res_valid}, 32'd0);

        // Right shift and zero shamt, back to back
        push(8'b0101_1100, 3'd5, 1'b0);
        push(8'hA5, 3'd0, 1'b1);
        chk("right_const", {24'd0, res_out}, 32'h02);
        step();
        chk("zero_shamt_const", {24'd0, res_out}, 32'hA5);
        drain();

        // Fill under back-pressure: one in result register, four in FIFO
        res_ready = 1'b0;
        push(8'h81, 3'd1, 1'b1);
        push(8'hFF, 3'd7, 1'b0);
        push(8'h3C, 3'd2, 1'b1);
        push(8'hC3, 3'd4, 1'b0);
        push(8'h01, 3'd7, 1'b1);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_res_valid", {31'd0, res_valid}, 32'd1);
        cmd_in    = 8'hEE;
        cmd_shamt = 3'd1;
        cmd_dir   = 1'b1;
        cmd_valid = 1'b1;
        step();
        step();
        cmd_valid = 1'b0;
        chk("full_ignored_count", {29'd0, count}, 32'd4);
        chk("stall_hold_out", {24'd0, res_out}, 32'h02);
        base      = n_consumed;
        res_ready = 1'b1;
        repeat (5) step();
        chk("throughput", n_consumed - base, 32'd5);
        chk("drained_count", {29'd0, count}, 32'd0);
        drain();

        // Simultaneous push and pop at count = 2
        res_ready = 1'b0;
        push(8'h11, 3'd1, 1'b1);
        push(8'h22, 3'd1, 1'b0);
        push(8'h33, 3'd2, 1'b1);
        chk("pp_pre_count", {29'd0, count}, 32'd2);
        res_ready = 1'b1;
        push(8'h44, 3'd3, 1'b0);
        chk("pp_count_a", {29'd0, count}, 32'd2);
        push(8'h55, 3'd6, 1'b1);
        chk("pp_count_b", {29'd0, count}, 32'd2);
        drain();

        // Mid-stream reset discards everything queued
        res_ready = 1'b0;
        push(8'h90, 3'd1, 1'b0);
        push(8'hA0, 3'd2, 1'b0);
        push(8'hB0, 3'd3, 1'b0);
        push(8'hC0, 3'd4, 1'b0);
        chk("mid_pre_count", {29'd0, count}, 32'd3);
        chk("mid_pre_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_count", {29'd0, count}, 32'd0);
        chk("mid_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_res_out", {24'd0, res_out}, 32'h00);
        chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        res_ready = 1'b1;
        repeat (3) step();
        chk("mid_idle_valid", {31'd0, res_valid}, 32'd0);
        push(8'h0F, 3'd4, 1'b1);
        step();
        chk("mid_new_result", {24'd0, res_out}, 32'hF0);
        drain();

        // Random traffic with random back-pressure
        for (int i = 0; i < 60; i++) begin
            res_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                cmd_in    = 8'($urandom);
                cmd_shamt = 3'($urandom);
                cmd_dir   = 1'($urandom);
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        cmd_valid = 1'b0;
        drain();
        chk("final_sb_empty", sb.size(), 32'd0);
        chk("final_count", {29'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
